// File: rtl/jtpinpon_obj_pkg.sv
// Shared constants, field codes, FSM states and the queued-entry record
// for the PinPon per-line object scheduler.
package jtpinpon_obj_pkg;

    localparam int MAXOBJ = 24;
    localparam int HALF   = 19;

    localparam logic [1:0] FLD_Y    = 2'd0;
    localparam logic [1:0] FLD_CODE = 2'd1;
    localparam logic [1:0] FLD_X    = 2'd2;
    localparam logic [1:0] FLD_ATTR = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        RD_Y,
        RD_CODE,
        RD_X,
        RD_ATTR,
        PUSH,
        DRAIN
    } sched_state_t;

    typedef struct packed {
        logic [7:0] code;
        logic [7:0] xpos;
        logic [7:0] attr;
        logic [3:0] v;
    } obj_entry_t;

    // Table Y is stored inverted; some entries sit one line lower.
    function automatic logic [7:0] obj_ypos(input logic [7:0] yraw, input logic adj);
        return ~yraw + {7'd0, adj};
    endfunction

endpackage

// File: rtl/jtpinpon_objsched_if.sv
// Valid/ready link between the object scheduler and the object draw engine.
interface jtpinpon_objsched_if;
    logic       dr_valid;
    logic       dr_ready;
    logic [7:0] dr_code;
    logic [7:0] dr_xpos;
    logic [7:0] dr_attr;
    logic [3:0] dr_v;

    modport master (output dr_valid, dr_code, dr_xpos, dr_attr, dr_v, input dr_ready);
    modport slave  (input dr_valid, dr_code, dr_xpos, dr_attr, dr_v, output dr_ready);
endinterface

// File: rtl/jtpinpon_objsched_fifo.sv
// Small synchronous FIFO of queued sprite entries; head is read straight
// from registered storage so it stays stable while the consumer stalls.
module jtpinpon_objsched_fifo
    import jtpinpon_obj_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  obj_entry_t din,
    output logic       full,
    output logic       empty,
    output obj_entry_t head
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

    obj_entry_t       mem_q [DEPTH];
    obj_entry_t       mem_d [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full  = (cnt_q == CNT_FULL);
    assign empty = (cnt_q == '0);
    assign head  = mem_q[rd_q];

    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        do_push = push & ~full;
        do_pop  = pop & ~empty;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_q] = din;
                wr_d        = wr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_d = rd_q + PTR_W'(1);
            end
            cnt_d = cnt_q + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_mem
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) mem_q[gi] <= '0;
                else        mem_q[gi] <= mem_d[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/jtpinpon_objsched.sv
// Per-line object-table scan: reads Y/code/X/attr for each entry, queues
// in-zone sprites for the draw engine. Optional per-line cap: OBJSCHED_LIMIT_EN.
module jtpinpon_objsched
    import jtpinpon_obj_pkg::*;
#(
    parameter int REV_SCAN   = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int LIMIT      = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cen2,
    input  logic                       hinit,
    input  logic [7:0]                 vrender,
    output logic [6:0]                 scan_addr,
    input  logic [7:0]                 scan_dout,
    jtpinpon_objsched_if.master        dr,
    output logic                       line_done,
    output logic                       overflow
);
    localparam logic [4:0] ENTRY_FIRST = (REV_SCAN != 0) ? 5'(MAXOBJ-1) : 5'd0;
    localparam logic [4:0] ENTRY_LAST  = (REV_SCAN != 0) ? 5'd0 : 5'(MAXOBJ-1);

    sched_state_t state_q, state_d;
    logic [4:0]   entry_q, entry_d;
    logic [1:0]   field_q, field_d;
    logic [7:0]   code_q, code_d, xpos_q, xpos_d, attr_q, attr_d;
    logic [3:0]   v_q, v_d;
    logic         inzone_q, inzone_d;
    logic         line_done_q, line_done_d;
    logic         overflow_q, overflow_d;
    logic         hinit_pend_q, hinit_pend_d;
    logic         hinit_q, hinit_d;

    logic         adj, advance, limit_hit;
    logic [7:0]   y, vend;
    logic         fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
    obj_entry_t   fifo_head;

`ifdef OBJSCHED_LIMIT_EN
    logic [5:0]   pushcnt_q, pushcnt_d;
    assign limit_hit = (pushcnt_q >= 6'(LIMIT));
`else
    logic         unused_limit;
    assign unused_limit = (LIMIT == 0);
    assign limit_hit    = 1'b0;
`endif

    assign adj  = (REV_SCAN != 0) ? (entry_q < 5'(HALF)) : (entry_q > 5'(HALF));
    assign y    = obj_ypos(scan_dout, adj);
    assign vend = vrender + 8'd16;

    always_comb begin
        state_d     = state_q;
        entry_d     = entry_q;
        field_d     = field_q;
        code_d      = code_q;
        xpos_d      = xpos_q;
        attr_d      = attr_q;
        v_d         = v_q;
        inzone_d    = inzone_q;
        line_done_d = line_done_q;
        overflow_d  = overflow_q;
        hinit_d     = hinit;
        fifo_push   = 1'b0;
        fifo_flush  = 1'b0;
        advance     = 1'b0;
`ifdef OBJSCHED_LIMIT_EN
        pushcnt_d   = pushcnt_q;
`endif
        // Rising edge only, so a long hinit pulse restarts the scan once.
        hinit_pend_d = (hinit & ~hinit_q) | (hinit_pend_q & ~cen2);

        if (cen2) begin
            if (hinit_pend_q) begin
                fifo_flush  = (state_q != IDLE);
                overflow_d  = (state_q != IDLE) && (state_q != DRAIN);
                entry_d     = ENTRY_FIRST;
                field_d     = FLD_Y;
                line_done_d = 1'b0;
                state_d     = RD_Y;
`ifdef OBJSCHED_LIMIT_EN
                pushcnt_d   = '0;
`endif
            end else begin
                case (state_q)
                    IDLE: ;
                    RD_Y: begin
                        inzone_d = (y >= vrender) && (y < vend);
                        v_d      = vrender[3:0] - y[3:0] - 4'd1;
                        field_d  = FLD_CODE;
                        state_d  = RD_CODE;
                    end
                    RD_CODE: begin
                        code_d  = scan_dout;
                        field_d = FLD_X;
                        state_d = RD_X;
                    end
                    RD_X: begin
                        xpos_d  = scan_dout;
                        field_d = FLD_ATTR;
                        state_d = RD_ATTR;
                    end
                    RD_ATTR: begin
                        attr_d  = scan_dout;
                        state_d = PUSH;
                    end
                    PUSH: begin
                        if (!inzone_q) begin
                            advance = 1'b1;
                        end else if (limit_hit) begin
                            overflow_d = 1'b1;
                            advance    = 1'b1;
                        end else if (!fifo_full) begin
                            fifo_push = 1'b1;
                            advance   = 1'b1;
`ifdef OBJSCHED_LIMIT_EN
                            pushcnt_d = pushcnt_q + 6'd1;
`endif
                        end
                        if (advance) begin
                            if (entry_q == ENTRY_LAST) begin
                                state_d = DRAIN;
                            end else begin
                                entry_d = (REV_SCAN != 0) ? entry_q - 5'd1 : entry_q + 5'd1;
                                field_d = FLD_Y;
                                state_d = RD_Y;
                            end
                        end
                    end
                    DRAIN: begin
                        if (fifo_empty) begin
                            line_done_d = 1'b1;
                            state_d     = IDLE;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            entry_q      <= '0;
            field_q      <= FLD_Y;
            code_q       <= '0;
            xpos_q       <= '0;
            attr_q       <= '0;
            v_q          <= '0;
            inzone_q     <= 1'b0;
            line_done_q  <= 1'b1;
            overflow_q   <= 1'b0;
            hinit_pend_q <= 1'b0;
            hinit_q      <= 1'b0;
`ifdef OBJSCHED_LIMIT_EN
            pushcnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            entry_q      <= entry_d;
            field_q      <= field_d;
            code_q       <= code_d;
            xpos_q       <= xpos_d;
            attr_q       <= attr_d;
            v_q          <= v_d;
            inzone_q     <= inzone_d;
            line_done_q  <= line_done_d;
            overflow_q   <= overflow_d;
            hinit_pend_q <= hinit_pend_d;
            hinit_q      <= hinit_d;
`ifdef OBJSCHED_LIMIT_EN
            pushcnt_q    <= pushcnt_d;
`endif
        end
    end

    // Draw handshake runs every clk, independent of cen2.
    assign fifo_pop = ~fifo_empty & dr.dr_ready;

    jtpinpon_objsched_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .din   ('{code: code_q, xpos: xpos_q, attr: attr_q, v: v_q}),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    assign scan_addr   = {entry_q, field_q};
    assign line_done   = line_done_q;
    assign overflow    = overflow_q;
    assign dr.dr_valid = ~fifo_empty;
    assign dr.dr_code  = fifo_head.code;
    assign dr.dr_xpos  = fifo_head.xpos;
    assign dr.dr_attr  = fifo_head.attr;
    assign dr.dr_v     = fifo_head.v;

endmodule

// File: tb/tb_jtpinpon_objsched.sv
// Scoreboard bench for jtpinpon_objsched: a RAM model feeds the scan and
// expected draw entries are queued from an independent table model.
`timescale 1ns/1ps
module tb_jtpinpon_objsched;

    localparam int N_OBJ  = 24;
    localparam int N_HALF = 19;
    localparam int LIMIT  = 8;
`ifdef OBJSCHED_LIMIT_EN
    localparam bit LIM_ON = 1'b1;
`else
    localparam bit LIM_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cen2 = 1'b0;
    logic       hinit = 1'b0;
    logic [7:0] vrender = 8'd0;
    logic [7:0] scan_dout = 8'd0;
    logic [6:0] scan_addr;
    logic       line_done;
    logic       overflow;

    jtpinpon_objsched_if dr_if();

    logic [7:0]  ram [128];
    logic [27:0] exp_q [$];
    int checks = 0;
    int failures = 0;
    int hs_cnt = 0;

    jtpinpon_objsched #(
        .REV_SCAN   (1),
        .FIFO_DEPTH (4),
        .LIMIT      (LIMIT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cen2      (cen2),
        .hinit     (hinit),
        .vrender   (vrender),
        .scan_addr (scan_addr),
        .scan_dout (scan_dout),
        .dr        (dr_if),
        .line_done (line_done),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;
    always @(negedge clk) cen2 = ~cen2;
    always @(posedge clk) scan_dout <= ram[scan_addr];

    // Handshake monitor: every accepted entry is compared with the scoreboard.
    always @(negedge clk) begin : monitor
        logic [27:0] got, want;
        if (rst_n && dr_if.dr_valid && dr_if.dr_ready) begin
            got = {dr_if.dr_code, dr_if.dr_xpos, dr_if.dr_attr, dr_if.dr_v};
            checks++;
            hs_cnt++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL handshake_unexpected got=%h required=none", got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    failures++;
                    $display("FAIL handshake_data got=%h required=%h", got, want);
                end else begin
                    $display("HS code=%h xpos=%h attr=%h v=%h", dr_if.dr_code, dr_if.dr_xpos,
                             dr_if.dr_attr, dr_if.dr_v);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_entry(input int e, input logic [7:0] yb, input logic [7:0] c,
                             input logic [7:0] x, input logic [7:0] a);
        ram[e*4]   = yb;
        ram[e*4+1] = c;
        ram[e*4+2] = x;
        ram[e*4+3] = a;
    endtask

    task automatic clear_ram();
        for (int i = 0; i < 128; i++) ram[i] = 8'h00;
    endtask

    // Entries lo..hi placed in zone of vr at offsets (e & mask).
    task automatic fill_zone(input logic [7:0] vr, input int lo, input int hi, input logic [3:0] mask);
        for (int e = lo; e <= hi; e++) begin
            logic [7:0] t, adj;
            logic [4:0] e5;
            e5  = 5'(e);
            t   = vr + {4'd0, e5[3:0] & mask};
            adj = (e < N_HALF) ? 8'd1 : 8'd0;
            set_entry(e, ~(t - adj), 8'h80 + 8'(e), 8'(e * 7), {e5[0], ~e5[0], 1'b0, e5});
        end
    endtask

    task automatic model_expect(input logic [7:0] vr, input bit use_limit);
        int n;
        n = 0;
        for (int e = N_OBJ - 1; e >= 0; e--) begin
            logic [7:0] y, ve, d;
            y  = ~ram[e*4] + ((e < N_HALF) ? 8'd1 : 8'd0);
            ve = vr + 8'd16;
            if (y >= vr && y < ve) begin
                if (!(use_limit && n >= LIMIT)) begin
                    d = vr - y - 8'd1;
                    exp_q.push_back({ram[e*4+1], ram[e*4+2], ram[e*4+3], d[3:0]});
                    n++;
                end
            end
        end
    endtask

    task automatic pulse_hinit(input logic [7:0] vr);
        vrender = vr;
        hinit = 1'b1;
        tick(1);
        hinit = 1'b0;
    endtask

    task automatic wait_line(output bit ok);
        bit dropped;
        dropped = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!line_done) begin
                dropped = 1'b1;
                break;
            end
            tick(1);
        end
        for (int i = 0; i < 3000; i++) begin
            if (line_done) begin
                ok = dropped;
                break;
            end
            tick(1);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (scan_addr !== 7'd0) begin failures++; $display("FAIL reset_scan_addr got=%h required=00", scan_addr); end
        checks++;
        if (dr_if.dr_valid !== 1'b0) begin failures++; $display("FAIL reset_dr_valid got=%b required=0", dr_if.dr_valid); end
        checks++;
        if ({dr_if.dr_code, dr_if.dr_xpos, dr_if.dr_attr, dr_if.dr_v} !== 28'd0) begin
            failures++;
            $display("FAIL reset_dr_data got=%h required=0000000",
                     {dr_if.dr_code, dr_if.dr_xpos, dr_if.dr_attr, dr_if.dr_v});
        end
        checks++;
        if (line_done !== 1'b1) begin failures++; $display("FAIL reset_line_done got=%b required=1", line_done); end
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b required=0", overflow); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(3);
        $display("test_reset done");
    endtask

    task automatic test_single();
        bit ok;
        int hs0;
        clear_ram();
        set_entry(23, 8'h8F, 8'h12, 8'h34, 8'hC5);
        exp_q.push_back({8'h12, 8'h34, 8'hC5, 4'h4});
        dr_if.dr_ready = 1'b1;
        hs0 = hs_cnt;
        pulse_hinit(8'h65);
        wait_line(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL single_line_done got=timeout required=done"); end
        checks++;
        if (hs_cnt - hs0 != 1) begin failures++; $display("FAIL single_count got=%0d required=1", hs_cnt - hs0); end
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("FAIL single_overflow got=%b required=0", overflow); end
        $display("test_single done");
    endtask

    task automatic test_adj();
        bit ok;
        int hs0;
        clear_ram();
        set_entry(5, 8'h8F, 8'hA1, 8'hB2, 8'h83);
        exp_q.push_back({8'hA1, 8'hB2, 8'h83, 4'hF});
        hs0 = hs_cnt;
        pulse_hinit(8'h71);
        wait_line(ok);
        checks++;
        if (!ok || hs_cnt - hs0 != 1) begin
            failures++;
            $display("FAIL adj_count got=%0d ok=%b required=1", hs_cnt - hs0, ok);
        end
        $display("test_adj done");
    endtask

    task automatic test_backpressure();
        bit ok;
        int hs0;
        clear_ram();
        fill_zone(8'h40, 0, 23, 4'hF);
        model_expect(8'h40, 1'b0);
        dr_if.dr_ready = 1'b0;
        hs0 = hs_cnt;
        pulse_hinit(8'h40);
        tick(300);
        checks++;
        if (dr_if.dr_valid !== 1'b1) begin failures++; $display("FAIL bp_valid got=%b required=1", dr_if.dr_valid); end
        checks++;
        if (scan_addr !== {5'd19, 2'd3}) begin failures++; $display("FAIL bp_frozen_addr got=%h required=%h", scan_addr, {5'd19, 2'd3}); end
        checks++;
        if (line_done !== 1'b0) begin failures++; $display("FAIL bp_line_done got=%b required=0", line_done); end
        tick(20);
        checks++;
        if (scan_addr !== {5'd19, 2'd3}) begin failures++; $display("FAIL bp_still_frozen got=%h required=%h", scan_addr, {5'd19, 2'd3}); end
        checks++;
        if ({dr_if.dr_code, dr_if.dr_xpos, dr_if.dr_attr, dr_if.dr_v} !== exp_q[0]) begin
            failures++;
            $display("FAIL bp_head_stable got=%h required=%h",
                     {dr_if.dr_code, dr_if.dr_xpos, dr_if.dr_attr, dr_if.dr_v}, exp_q[0]);
        end
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            dr_if.dr_ready = 1'($urandom_range(0, 1));
            tick(1);
            if (line_done) begin
                ok = 1'b1;
                break;
            end
        end
        dr_if.dr_ready = 1'b1;
        checks++;
        if (!ok) begin failures++; $display("FAIL bp_line_done_end got=timeout required=done"); end
        checks++;
        if (hs_cnt - hs0 != 24) begin failures++; $display("FAIL bp_count got=%0d required=24", hs_cnt - hs0); end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL bp_leftover got=%0d required=0", exp_q.size()); end
        $display("test_backpressure done");
    endtask

    task automatic test_abort();
        bit ok, found;
        int hs0;
        clear_ram();
        set_entry(23, 8'hBF, 8'h51, 8'h61, 8'h71);
        set_entry(22, 8'hBF, 8'h52, 8'h62, 8'h72);
        model_expect(8'h40, 1'b0);
        dr_if.dr_ready = 1'b0;
        hs0 = hs_cnt;
        pulse_hinit(8'h40);
        found = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (scan_addr == {5'd10, 2'd2}) begin found = 1'b1; break; end
            tick(1);
        end
        checks++;
        if (!found || dr_if.dr_valid !== 1'b1) begin
            failures++;
            $display("FAIL abort_reach_rdx got=%b valid=%b required=1", found, dr_if.dr_valid);
        end
        exp_q.delete();
        model_expect(8'h40, 1'b0);
        pulse_hinit(8'h40);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (scan_addr == {5'd23, 2'd0}) begin found = 1'b1; break; end
            tick(1);
        end
        checks++;
        if (!found) begin failures++; $display("FAIL abort_restart_addr got=%h required=%h", scan_addr, {5'd23, 2'd0}); end
        checks++;
        if (dr_if.dr_valid !== 1'b0) begin failures++; $display("FAIL abort_flush got=%b required=0", dr_if.dr_valid); end
        checks++;
        if (overflow !== 1'b1) begin failures++; $display("FAIL abort_overflow got=%b required=1", overflow); end
        dr_if.dr_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (line_done) begin ok = 1'b1; break; end
            tick(1);
        end
        checks++;
        if (!ok || hs_cnt - hs0 != 2) begin
            failures++;
            $display("FAIL abort_count got=%0d ok=%b required=2", hs_cnt - hs0, ok);
        end
        checks++;
        if (overflow !== 1'b1) begin failures++; $display("FAIL abort_overflow_end got=%b required=1", overflow); end
        $display("test_abort done");
    endtask

    task automatic test_offscreen();
        bit ok;
        int hs0;
        for (int i = 0; i < 128; i++) ram[i] = 8'($urandom);
        model_expect(8'hF8, 1'b0);
        hs0 = hs_cnt;
        pulse_hinit(8'hF8);
        wait_line(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL off_line_done got=timeout required=done"); end
        checks++;
        if (hs_cnt - hs0 != 0) begin failures++; $display("FAIL off_count got=%0d required=0", hs_cnt - hs0); end
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("FAIL off_overflow got=%b required=0", overflow); end
        $display("test_offscreen done");
    endtask

    task automatic test_limit();
        bit ok;
        int hs0;
        clear_ram();
        fill_zone(8'h30, 12, 23, 4'h7);
        model_expect(8'h30, LIM_ON);
        hs0 = hs_cnt;
        pulse_hinit(8'h30);
        wait_line(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL limit_line_done got=timeout required=done"); end
        checks++;
        if (hs_cnt - hs0 != (LIM_ON ? 8 : 12)) begin
            failures++;
            $display("FAIL limit_count got=%0d required=%0d", hs_cnt - hs0, LIM_ON ? 8 : 12);
        end
        checks++;
        if (overflow !== LIM_ON) begin failures++; $display("FAIL limit_overflow got=%b required=%b", overflow, LIM_ON); end
        $display("test_limit done");
    endtask

    task automatic test_async_reset();
        clear_ram();
        fill_zone(8'h40, 0, 23, 4'hF);
        dr_if.dr_ready = 1'b0;
        pulse_hinit(8'h40);
        tick(100);
        #3;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        checks++;
        if (dr_if.dr_valid !== 1'b0) begin failures++; $display("FAIL areset_valid got=%b required=0", dr_if.dr_valid); end
        checks++;
        if (scan_addr !== 7'd0) begin failures++; $display("FAIL areset_addr got=%h required=00", scan_addr); end
        checks++;
        if (line_done !== 1'b1) begin failures++; $display("FAIL areset_line_done got=%b required=1", line_done); end
        tick(2);
        rst_n = 1'b1;
        dr_if.dr_ready = 1'b1;
        tick(10);
        checks++;
        if (dr_if.dr_valid !== 1'b0 || line_done !== 1'b1) begin
            failures++;
            $display("FAIL areset_idle got=%b%b required=01", dr_if.dr_valid, line_done);
        end
        $display("test_async_reset done");
    endtask

    initial begin
        dr_if.dr_ready = 1'b0;
        clear_ram();
        test_reset();
        test_single();
        test_adj();
        test_backpressure();
        test_abort();
        test_offscreen();
        test_limit();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
